status_led_ctrl: RTL

- Output-side counterpart of the key input path. Key/debounce logic turns a physical input into a control level; this block turns design status into a visible LED pattern for the user.
- Takes DDR3 calibration status, the read-enable level driven by the key control, an error pulse and a read-activity pulse.
- Drives one board LED with prioritised solid, blink and flash patterns.
- Sits at top level beside the key control logic, in the same clock domain.

---
 rtl/status_led_ctrl_pkg.sv | 27 ++
 rtl/status_led_ctrl_blink_gen.sv | 37 +++
 rtl/status_led_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/status_led_ctrl_pkg.sv
// Shared definitions for the user-interface status blocks: mode encodings
// and the cycle-count derivations used by the LED timers.
package status_led_ctrl_pkg;

    typedef logic [27:0] cyc_t;

    typedef enum logic [1:0] {
        MODE_CALIB = 2'b00,
        MODE_IDLE  = 2'b01,
        MODE_RUN   = 2'b10,
        MODE_ERR   = 2'b11
    } mode_e;

    // Evaluated only at elaboration to build localparams; never in hardware.
    function automatic cyc_t halfCycles(input cyc_t freq, input cyc_t hz);
        return freq / (28'd2 * hz);
    endfunction

    function automatic cyc_t flashCycles(input cyc_t freq, input cyc_t ms);
        return (freq / 28'd1000) * ms;
    endfunction

    localparam cyc_t SLOW_CYC  = halfCycles(28'd25_000_000, 28'd1);
    localparam cyc_t FAST_CYC  = halfCycles(28'd25_000_000, 28'd4);
    localparam cyc_t FLASH_CYC = flashCycles(28'd25_000_000, 28'd100);

endpackage

// File: rtl/status_led_ctrl_blink_gen.sv
// Half-period counter for LED blinking: tick_o marks the cycle on which the
// owner should toggle its LED register.
module led_blink_gen
    import status_led_ctrl_pkg::*;
#(
    parameter cyc_t HALF = 28'd1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);

    cyc_t cnt_q;
    cyc_t cnt_d;

    assign tick_o = enable_i && (cnt_q == HALF - 28'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 28'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/status_led_ctrl.sv
// Turns calibration, read-enable, error and activity status into a single
// prioritised LED pattern (solid, slow/fast blink, activity flash).
module status_led_ctrl
    import status_led_ctrl_pkg::*;
#(
    parameter cyc_t FREQ     = 28'd25_000_000,
    parameter cyc_t SLOW_HZ  = 28'd1,
    parameter cyc_t FAST_HZ  = 28'd4,
    parameter cyc_t FLASH_MS = 28'd100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       calib_done,
    input  logic       rd_en,
    input  logic       act_pulse,
    input  logic       err_pulse,
    input  logic       err_clr,
    output logic       led,
    output logic       err_latched,
    output logic [1:0] mode
);

    localparam cyc_t SLOW_HALF = halfCycles(FREQ, SLOW_HZ);
    localparam cyc_t FAST_HALF = halfCycles(FREQ, FAST_HZ);
    localparam cyc_t FLASH_LEN = flashCycles(FREQ, FLASH_MS);

    mode_e mode_q, mode_d;
    logic  led_q, led_d;
    logic  err_q, err_d;
    logic  armed_q;
    logic  flash_q, flash_d;
    logic  gap_q, gap_d;
    cyc_t  flashCnt_q, flashCnt_d;

    logic  entry;
    logic  flashLast;
    logic  flashFree;
    logic  slowTick;
    logic  fastTick;

    // The first edge after reset counts as an entry so the CALIB blink starts lit.
    assign entry     = (mode_d != mode_q) || !armed_q;
    assign flashLast = (flashCnt_q == FLASH_LEN - 28'd1);
    assign flashFree = (!flash_q && !gap_q) || (gap_q && flashLast);

    led_blink_gen #(.HALF(SLOW_HALF)) uSlow (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (entry),
        .enable_i ((mode_d == MODE_CALIB) && !entry),
        .tick_o   (slowTick)
    );

    led_blink_gen #(.HALF(FAST_HALF)) uFast (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (entry),
        .enable_i ((mode_d == MODE_ERR) && !entry),
        .tick_o   (fastTick)
    );

    always_comb begin
        err_d      = err_pulse ? 1'b1 : (err_clr ? 1'b0 : err_q);
        flash_d    = 1'b0;
        gap_d      = 1'b0;
        flashCnt_d = '0;
        led_d      = 1'b0;

        if (err_d)            mode_d = MODE_ERR;
        else if (!calib_done) mode_d = MODE_CALIB;
        else if (rd_en)       mode_d = MODE_RUN;
        else                  mode_d = MODE_IDLE;

        case (mode_d)
            MODE_CALIB: led_d = entry ? 1'b1 : (led_q ^ slowTick);
            MODE_ERR:   led_d = entry ? 1'b1 : (led_q ^ fastTick);
            MODE_RUN: begin
                if (flash_q && !flashLast) begin
                    flash_d    = 1'b1;
                    flashCnt_d = flashCnt_q + 28'd1;
                    led_d      = 1'b0;
                end else if (flash_q) begin
                    gap_d = 1'b1;
                    led_d = 1'b1;
                end else if (act_pulse && flashFree) begin
                    flash_d = 1'b1;
                    led_d   = 1'b0;
                end else if (gap_q && !flashLast) begin
                    gap_d      = 1'b1;
                    flashCnt_d = flashCnt_q + 28'd1;
                    led_d      = 1'b1;
                end else begin
                    led_d = 1'b1;
                end
            end
            default: led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_CALIB;
            led_q      <= 1'b0;
            err_q      <= 1'b0;
            armed_q    <= 1'b0;
            flash_q    <= 1'b0;
            gap_q      <= 1'b0;
            flashCnt_q <= '0;
        end else begin
            mode_q     <= mode_d;
            led_q      <= led_d;
            err_q      <= err_d;
            armed_q    <= 1'b1;
            flash_q    <= flash_d;
            gap_q      <= gap_d;
            flashCnt_q <= flashCnt_d;
        end
    end

    assign led         = led_q;
    assign err_latched = err_q;
    assign mode        = mode_q;

endmodule
